// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter that feeds bytes to a UART transmitter.
// The winning byte is latched, presented on tx_data, and written with a
// tx_wr strobe. The arbiter then follows tx_busy to track the frame and
// pulses ack (plus err on a start timeout) when the frame completes or fails.
module uart_tx_arb #(
    parameter int START_TO   = 15,
    parameter int STROBE_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [15:0] frame_cnt,
    output logic        grant
);

    // One counter is shared by the strobe-width and start-timeout phases.
    localparam int CNT_MAX = (START_TO > STROBE_LEN) ? START_TO : STROBE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_wr_q, tx_wr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               err_q, err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               grant_q, grant_d;
    logic               winner;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        if (req0 && req1) begin
            winner = ~grant_q;
        end else begin
            winner = req1;
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_wr_d     = tx_wr_q;
        tx_data_d   = tx_data_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        grant_d     = grant_q;

        case (state_q)
            IDLE: begin
                // The line may be owned by someone else; only grant when free.
                if (!tx_busy && (req0 || req1)) begin
                    grant_d   = winner;
                    tx_data_d = winner ? data1 : data0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // tx_wr has been low for this whole cycle; raise it next.
                tx_wr_d = 1'b1;
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == CNT_W'(STROBE_LEN - 1)) begin
                    tx_wr_d = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TO - 1)) begin
                    // Transmitter never started: fail the frame, no count.
                    err_d   = 1'b1;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                // No timeout here: a frame may legitimately take a long time.
                if (!tx_busy) begin
                    ack0_d      = ~grant_q;
                    ack1_d      = grant_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_wr_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'h0000;
            grant_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_wr_q     <= tx_wr_d;
            tx_data_q   <= tx_data_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            grant_q     <= grant_d;
        end
    end

    assign tx_wr     = tx_wr_q;
    assign tx_data   = tx_data_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: stimulus pushes the expected frame
// outcome, a monitor pops and compares on every ack pulse.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [7:0]  data0, data1;
    logic        ack0, ack1, err;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [15:0] frame_cnt;
    logic        grant;

    uart_tx_arb #(.START_TO(15), .STROBE_LEN(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_busy   (tx_busy),
        .frame_cnt (frame_cnt),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        who;
        logic [7:0]  data;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acks_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Transmitter model: on a tx_wr rising edge it holds busy for busy_len cycles.
    logic model_en, model_busy, ext_busy, wr_prev;
    int   busy_len, busy_cnt;
    initial begin
        model_busy = 1'b0;
        wr_prev    = 1'b0;
        busy_cnt   = 0;
    end
    always @(negedge clk) begin
        if (model_en && tx_wr && !wr_prev && busy_cnt == 0) begin
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        model_busy = (busy_cnt > 0);
        wr_prev    = tx_wr;
    end
    assign tx_busy = model_busy | ext_busy;

    // Monitor: compare tx_data while strobing and the full outcome on each ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_wr && exp_q.size() > 0) begin
                chk("tx_data_at_strobe", {24'h0, tx_data}, {24'h0, exp_q[0].data});
            end
            if (ack0 || ack1) begin
                exp_t e;
                acks_seen++;
                chk("single_ack", {31'h0, ack0 & ack1}, 32'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {31'h0, ack1}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("ack: who=%0d data=%02h err=%0d frame_cnt=%04h", ack1, tx_data, err, frame_cnt);
                    chk("ack_who",   {31'h0, ack1},      {31'h0, e.who});
                    chk("grant",     {31'h0, grant},     {31'h0, e.who});
                    chk("tx_data",   {24'h0, tx_data},   {24'h0, e.data});
                    chk("err",       {31'h0, err},       {31'h0, e.err});
                    chk("frame_cnt", {16'h0, frame_cnt}, {16'h0, e.cnt});
                end
            end else begin
                chk("err_without_ack", {31'h0, err}, 32'h0);
            end
        end
    end

    int         lat;
    logic [3:0] wh;
    logic       saw;
    int         n;

    // Wait for an ack, recording latency and the first four tx_wr samples.
    task automatic wait_ack(input int budget, output int lat_o, output logic [3:0] wh_o);
        lat_o = 0;
        wh_o  = 4'h0;
        while (1) begin
            @(posedge clk);
            #1;
            lat_o++;
            if (lat_o <= 4) wh_o[lat_o-1] = tx_wr;
            if (ack0 || ack1) break;
            if (lat_o >= budget) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout actual=no ack after %0d cycles required=ack", lat_o);
                break;
            end
        end
    endtask

    task automatic check_reset_values();
        chk("rst_tx_wr",     {31'h0, tx_wr},     32'h0);
        chk("rst_tx_data",   {24'h0, tx_data},   32'h0);
        chk("rst_acks",      {30'h0, ack1, ack0}, 32'h0);
        chk("rst_err",       {31'h0, err},       32'h0);
        chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        chk("rst_grant",     {31'h0, grant},     32'h1);
    endtask

    task automatic gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        model_en = 1'b1; ext_busy = 1'b0; busy_len = 169;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk) rst_n = 1'b1;

        // Single frame, 169-cycle transmitter.
        @(posedge clk); #1;
        exp_q.push_back('{1'b0, 8'hA5, 1'b0, 16'd1});
        data0 = 8'hA5; req0 = 1'b1;
        wait_ack(400, lat, wh);
        req0 = 1'b0;
        chk("single_tx_wr_shape", {28'h0, wh}, 32'h6);
        chk("single_ack_latency", lat, 32'd172);

        // Tie from a fresh reset: alternate 0x11, 0x22, 0x11, 0x22.
        gap();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        busy_len = 5;
        exp_q.push_back('{1'b0, 8'h11, 1'b0, 16'd1});
        exp_q.push_back('{1'b1, 8'h22, 1'b0, 16'd2});
        exp_q.push_back('{1'b0, 8'h11, 1'b0, 16'd3});
        exp_q.push_back('{1'b1, 8'h22, 1'b0, 16'd4});
        data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) wait_ack(100, lat, wh);
        req0 = 1'b0; req1 = 1'b0;

        // Start timeout: transmitter silent.
        gap();
        model_en = 1'b0;
        exp_q.push_back('{1'b1, 8'h5A, 1'b1, 16'd4});
        data1 = 8'h5A; req1 = 1'b1;
        wait_ack(100, lat, wh);
        req1 = 1'b0;
        chk("timeout_tx_wr_shape", {28'h0, wh}, 32'h6);
        chk("timeout_ack_latency", lat, 32'd19);
        model_en = 1'b1;

        // Reset during WAIT_DONE: no ack, then wait for the line to go free.
        gap();
        busy_len = 50;
        data0 = 8'h3C; req0 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        req0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back('{1'b1, 8'h77, 1'b0, 16'd1});
        data1 = 8'h77; req1 = 1'b1;
        saw = 1'b0; n = 0;
        while (tx_busy && n < 200) begin
            @(posedge clk); #1;
            if (tx_wr) saw = 1'b1;
            n++;
        end
        chk("rst_no_wr_while_busy", {31'h0, saw}, 32'h0);
        chk("rst_busy_fell", {31'h0, (n < 200)}, 32'h1);
        wait_ack(200, lat, wh);
        req1 = 1'b0;

        // Data change one cycle after grant must not reach tx_data.
        gap();
        exp_q.push_back('{1'b0, 8'h42, 1'b0, 16'd2});
        data0 = 8'h42; req0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data0 = 8'hFF;
        wait_ack(400, lat, wh);
        req0 = 1'b0;

        // External busy in IDLE plus counter wrap (counter preloaded to
        // shorten the run instead of sending 65534 frames).
        gap();
        @(negedge clk) dut.frame_cnt_q = 16'hFFFE;
        busy_len = 5;
        @(posedge clk); #1;
        exp_q.push_back('{1'b0, 8'hC3, 1'b0, 16'hFFFF});
        ext_busy = 1'b1; data0 = 8'hC3; req0 = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_wr) saw = 1'b1;
        end
        chk("ext_busy_no_wr", {31'h0, saw}, 32'h0);
        ext_busy = 1'b0;
        wait_ack(100, lat, wh);
        req0 = 1'b0;
        gap();
        exp_q.push_back('{1'b1, 8'h99, 1'b0, 16'h0000});
        data1 = 8'h99; req1 = 1'b1;
        wait_ack(100, lat, wh);
        req1 = 1'b0;

        gap();
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        chk("ack_total", acks_seen, 32'd10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
